// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between a load/store master and data_mem_lsu.
interface data_mem_lsu_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req;
    logic                     write_en;
    logic [2:0]               funct3;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data_in;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    data_out;
    logic                     access_err;
    logic                     busy;

    modport master (
        output req, write_en, funct3, addr, data_in,
        input  ready, data_out, access_err, busy
    );

    modport slave (
        input  req, write_en, funct3, addr, data_in,
        output ready, data_out, access_err, busy
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with RV32 sub-word load/store, programmable
// wait states, a zeroing sweep after reset and misaligned/illegal flagging.
//
// state  | meaning
// INIT   | clear sweep, one word zeroed per cycle, requests ignored
// IDLE   | waiting for req; request fields latched on acceptance
// WAIT   | wait-state down-counter running, DONE at terminal count
// DONE   | access performed; ready/data_out/access_err registered on exit
module data_mem_lsu #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 256,
    parameter int WAIT_STATES   = 1
) (
    input  logic           clk,
    input  logic           clr,
    data_mem_lsu_if.slave  bus
);
    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]      ptr;
    logic [2:0]            wait_cnt;
    logic                  lat_we;
    logic [2:0]            lat_f3;
    logic [IDX_W+1:0]      lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;

    logic                  ready_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dout_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic [1:0]            off;
    logic                  misaligned;
    logic                  illegal;
    logic                  err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [3:0]            st_lanes;
    logic [DATA_WIDTH-1:0] st_data;

    logic [3:0]            mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Upper address bits only alias; they never reach the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[ADDRESS_WIDTH-1:IDX_W+2];

    assign idx = lat_addr[IDX_W+1:2];
    assign off = lat_addr[1:0];

    // Access decode from latched request: error flags, load extraction, store lanes.
    always_comb begin
        misaligned = ((lat_f3[1:0] == 2'b01) && off[0]) ||
                     ((lat_f3[1:0] == 2'b10) && (off != 2'b00));
        illegal    = (lat_f3 == 3'b011) || (lat_f3[2:1] == 2'b11) ||
                     (lat_we && lat_f3[2]);
        err        = misaligned || illegal;

        rd_word = mem[idx];
        rd_byte = rd_word[{off, 3'b000} +: 8];
        rd_half = off[1] ? rd_word[31:16] : rd_word[15:0];
        case (lat_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = rd_word;
        endcase

        // Narrow stores replicate their data so the lane mask alone picks the target.
        case (lat_f3[1:0])
            2'b00: begin
                st_lanes = 4'b0001 << off;
                st_data  = {4{lat_data[7:0]}};
            end
            2'b01: begin
                st_lanes = off[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{lat_data[15:0]}};
            end
            default: begin
                st_lanes = 4'b1111;
                st_data  = lat_data;
            end
        endcase
    end

    // Next-state logic and memory write port selection.
    always_comb begin
        state_nxt = state;
        mem_we    = 4'b0000;
        mem_idx   = idx;
        mem_wdata = st_data;
        case (state)
            S_INIT: begin
                mem_we    = 4'b1111;
                mem_idx   = ptr;
                mem_wdata = '0;
                if (ptr == {IDX_W{1'b1}}) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (bus.req) state_nxt = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 3'd0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (lat_we && !err) mem_we = st_lanes;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // State register; clr restarts the sweep and abandons any access in flight.
    always_ff @(posedge clk) begin
        if (clr) state <= S_INIT;
        else     state <= state_nxt;
    end

    // Sweep pointer, wait counter, request latch and registered response.
    always_ff @(posedge clk) begin
        if (clr) begin
            ptr      <= '0;
            wait_cnt <= 3'd0;
            lat_we   <= 1'b0;
            lat_f3   <= 3'd0;
            lat_addr <= '0;
            lat_data <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            if (state == S_INIT) ptr <= ptr + 1'b1;
            if (state == S_IDLE && bus.req) begin
                lat_we   <= bus.write_en;
                lat_f3   <= bus.funct3;
                lat_addr <= bus.addr[IDX_W+1:0];
                lat_data <= bus.data_in;
                wait_cnt <= WS_LOAD;
            end
            if (state == S_WAIT) wait_cnt <= wait_cnt - 1'b1;
            if (state == S_DONE) begin
                ready_q <= 1'b1;
                err_q   <= err;
                if (err)          dout_q <= '0;
                else if (!lat_we) dout_q <= ld_data;
            end
        end
    end

    // Storage array, byte-lane write enables; nothing is written while clr is held.
    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_we[l]) mem[mem_idx][8*l +: 8] <= mem_wdata[8*l +: 8];
            end
        end
    end

    assign bus.ready      = ready_q & ~clr;
    assign bus.access_err = err_q & ~clr;
    assign bus.data_out   = clr ? '0 : dout_q;
    assign bus.busy       = clr | (state != S_IDLE);
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: three instances (1, 0 and 3 wait states)
// share stimulus, a selector routes req and picks which outputs are observed.
module tb_data_mem_lsu;
    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr;
    logic        req;
    logic        write_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data_in;
    int          sel;

    logic        ready_m;
    logic        err_m;
    logic        busy_m;
    logic [31:0] dout_m;

    int          n_cmp;
    int          n_fail;
    exp_t        sb[$];
    logic [31:0] mdo [3];

    data_mem_lsu_if bus0();
    data_mem_lsu_if bus1();
    data_mem_lsu_if bus2();

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.write_en = write_en;
    assign bus1.write_en = write_en;
    assign bus2.write_en = write_en;
    assign bus0.funct3 = funct3;
    assign bus1.funct3 = funct3;
    assign bus2.funct3 = funct3;
    assign bus0.addr = addr;
    assign bus1.addr = addr;
    assign bus2.addr = addr;
    assign bus0.data_in = data_in;
    assign bus1.data_in = data_in;
    assign bus2.data_in = data_in;

    data_mem_lsu #(.DEPTH(DEPTH), .WAIT_STATES(1)) dut0 (.clk(clk), .clr(clr), .bus(bus0));
    data_mem_lsu #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut1 (.clk(clk), .clr(clr), .bus(bus1));
    data_mem_lsu #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut2 (.clk(clk), .clr(clr), .bus(bus2));

    always_comb begin
        ready_m = bus0.ready;
        err_m   = bus0.access_err;
        busy_m  = bus0.busy;
        dout_m  = bus0.data_out;
        case (sel)
            1: begin
                ready_m = bus1.ready;
                err_m   = bus1.access_err;
                busy_m  = bus1.busy;
                dout_m  = bus1.data_out;
            end
            2: begin
                ready_m = bus2.ready;
                err_m   = bus2.access_err;
                busy_m  = bus2.busy;
                dout_m  = bus2.data_out;
            end
            default: ;
        endcase
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected data_out follows the model: loads update it, errors zero it, stores keep it.
    task automatic push_exp(input string tag, input logic we, input logic [31:0] exp_load,
                            input logic exp_err);
        exp_t e;
        if (exp_err)  mdo[sel] = 32'd0;
        else if (!we) mdo[sel] = exp_load;
        e.tag  = tag;
        e.err  = exp_err;
        e.data = mdo[sel];
        sb.push_back(e);
    endtask

    task automatic check_resp();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL unexpected_ready: observed ready with empty scoreboard, expected none");
        end else begin
            e = sb.pop_front();
            chk({e.tag, "/data"}, dout_m, e.data);
            chk({e.tag, "/err"}, {31'd0, err_m}, {31'd0, e.err});
        end
    endtask

    task automatic access(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_load, input logic exp_err);
        int   lat;
        exp_t drop;
        @(negedge clk);
        chk({tag, "/idle"}, {31'd0, busy_m}, 32'd0);
        write_en = we;
        funct3   = f3;
        addr     = a;
        data_in  = d;
        req      = 1'b1;
        push_exp(tag, we, exp_load, exp_err);
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready_m && lat < 20);
        chk({tag, "/latency"}, 32'(lat), 32'(ws_of(sel) + 1));
        if (ready_m) check_resp();
        else if (sb.size() != 0) drop = sb.pop_front();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int   cnt;
        logic seen;
        n_cmp    = 0;
        n_fail   = 0;
        sel      = 0;
        req      = 1'b0;
        write_en = 1'b0;
        funct3   = 3'd0;
        addr     = 32'd0;
        data_in  = 32'd0;
        clr      = 1'b1;
        for (int i = 0; i < 3; i++) mdo[i] = 32'd0;

        // reset state and sweep length
        @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready_m}, 32'd0);
        chk("rst_err",   {31'd0, err_m},   32'd0);
        chk("rst_dout",  dout_m,           32'd0);
        chk("rst_busy",  {31'd0, busy_m},  32'd1);
        clr = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (busy_m && cnt < 400);
        chk("sweep_cycles", 32'(cnt), 32'(DEPTH));

        // swept words read zero
        access("lw_0",   1'b0, 3'b010, 32'h000, 32'h0, 32'h0, 1'b0);
        access("lw_3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0);
        access("lw_200", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b0);

        // word round trip
        access("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        access("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // sub-word stores and loads
        access("sw_20",  1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        access("sb_21",  1'b1, 3'b000, 32'h21, 32'h123456A5, 32'h0, 1'b0);
        access("sh_22",  1'b1, 3'b001, 32'h22, 32'hABCD8001, 32'h0, 1'b0);
        access("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 32'h8001A544, 1'b0);
        access("lb_21",  1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFA5, 1'b0);
        access("lbu_21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000A5, 1'b0);
        access("lh_22",  1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0);
        access("lhu_22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0);
        access("lb_20",  1'b0, 3'b000, 32'h20, 32'h0, 32'h00000044, 1'b0);

        // error cases leave memory intact
        access("sw_20b",   1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        access("lw_ld_ok", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        access("err_lw22", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1);
        access("err_sh23", 1'b1, 3'b001, 32'h23, 32'h0000BEEF, 32'h0, 1'b1);
        access("err_f011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        access("err_s100", 1'b1, 3'b100, 32'h20, 32'h000000FF, 32'h0, 1'b1);
        access("lw_20c",   1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);

        // zero wait states: aliasing and back-to-back with req held high
        sel = 1;
        @(negedge clk);
        write_en = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h400;
        data_in  = 32'hCAFEF00D;
        req      = 1'b1;
        push_exp("b2b_sw", 1'b1, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        write_en = 1'b0;
        addr     = 32'h0;
        push_exp("b2b_lw", 1'b0, 32'hCAFEF00D, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_ready_%0d", k), {31'd0, ready_m}, {31'd0, (k % 2) == 1});
            if (ready_m) check_resp();
            if (k == 2) begin
                addr   = 32'h401;
                funct3 = 3'b000;
                push_exp("b2b_lb", 1'b0, 32'hFFFFFFF0, 1'b0);
            end
            if (k == 4) req = 1'b0;
        end
        access("lw_0_alias", 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        // three wait states, then clr during WAIT aborts a store
        sel = 2;
        access("ws3_sw", 1'b1, 3'b010, 32'h44, 32'h13579BDF, 32'h0, 1'b0);
        access("ws3_lw", 1'b0, 3'b010, 32'h44, 32'h0, 32'h13579BDF, 1'b0);
        @(negedge clk);
        write_en = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h40;
        data_in  = 32'h55AA55AA;
        req      = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        seen = ready_m;
        @(posedge clk);
        #1;
        seen = seen | ready_m;
        clr  = 1'b1;
        @(posedge clk);
        #1;
        seen = seen | ready_m;
        clr  = 1'b0;
        for (int i = 0; i < 3; i++) mdo[i] = 32'd0;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            seen = seen | ready_m;
            cnt++;
        end while (busy_m && cnt < 400);
        chk("abort_no_ready", {31'd0, seen}, 32'd0);
        chk("abort_sweep", 32'(cnt), 32'(DEPTH));
        access("abort_lw40", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0);
        access("abort_lw44", 1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Next-generation data memory for the RISC-V core. It has word-organised, parametrised-depth storage with RV32 sub-word load/store handling (byte, halfword and word; signed and unsigned loads). A req/ready handshake with configurable wait states lets the memory emulate slower RAM. A hardware clear sweep after reset zeroes the array one word per cycle, and misaligned or illegal accesses are flagged instead of silently corrupting data.

Parameters:
ADDRESS_WIDTH, 32, byte-address width.
DATA_WIDTH, 32, word width; only 32 is supported (4 byte lanes).
DEPTH, 256, number of words; must be a power of two, at least 4.
WAIT_STATES, 1, extra cycles between request acceptance and ready; legal range 0..7.

Ports:
clk  input  1  clock; all state updates on the rising edge.
clr  input  1  synchronous active-high reset; starts the clear sweep.
req  input  1  access request; sampled only in IDLE.
write_en  input  1  1 = store, 0 = load; sampled with req.
funct3  input  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  input  ADDRESS_WIDTH  byte address.
data_in  input  DATA_WIDTH  store data; the low bytes are used for SB and SH.
ready  output  1  one-cycle pulse marking access completion.
data_out  output  DATA_WIDTH  load result, extended to 32 bits; held between pulses.
access_err  output  1  valid with ready: the access was misaligned or illegal.
busy  output  1  high in every state except IDLE.

Behaviour:
- The clock is clk. Reset is clr: synchronous and active-high. While clr is high: FSM goes to INIT, sweep pointer = 0, ready = 0, access_err = 0, data_out = 0, busy = 1.
- FSM states: INIT, IDLE, WAIT, DONE.
- INIT: writes zero to word[ptr] each cycle and increments ptr. After writing word DEPTH-1 the FSM moves to IDLE, so INIT lasts exactly DEPTH cycles after clr falls. req is ignored during INIT.
- IDLE: if req=1, latch write_en, funct3, addr and data_in. Then:
  - if WAIT_STATES = 0, go to DONE;
  - otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter each cycle; go to DONE when the counter reaches 0.
- Timing: ready rises exactly WAIT_STATES+1 cycles after the acceptance edge. There is no pipelining; one access is outstanding at a time.
- DONE (one cycle): ready = 1, the access is performed, then the FSM returns to IDLE.
  - A new req can be accepted in the cycle after DONE.
  - A req held high continuously yields back-to-back accesses, one every WAIT_STATES+2 cycles.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Error checks, evaluated on the latched values:
  - misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0;
  - illegal: funct3 is 011, 110 or 111; or a store with funct3[2] = 1.
- On error: access_err = 1 with ready, no memory write, data_out = 0.
- Stores (little-endian): SB writes lane addr[1:0]; SH writes lanes addr[1]*2 and addr[1]*2+1; SW writes all lanes. Unwritten lanes are unchanged. data_out is left unchanged by a store.
- Loads: select the byte or halfword at the lane offset. Zero-extend for BU/HU; sign-extend for B/H. data_out is registered on the DONE edge and held until the next load or error.
- clr asserted mid-access aborts the access: no write occurs, no ready is issued, and the sweep restarts.
- access_err is low whenever ready is low.

Test Plan:
- Reset: clr high 1 cycle, DEPTH=256 -> busy high for 256 cycles, then IDLE; LW from 0x0, 0x3FC and 0x200 each return 0x00000000.
- Word round trip, WAIT_STATES=1: SW 0xDEADBEEF to 0x10, then LW 0x10 -> ready 2 cycles after each acceptance; data_out = 0xDEADBEEF; access_err = 0.
- Sub-word: SW 0x11223344 @0x20, SB 0xA5 @0x21, SH 0x8001 @0x22 -> LW = 0x8001A544, LB @0x21 = 0xFFFFFFA5, LBU @0x21 = 0x000000A5, LH @0x22 = 0xFFFF8001, LHU @0x22 = 0x00008001.
- Errors: LW @0x22, SH @0x23, funct3=011, store with funct3=100 -> each gives ready with access_err=1 and data_out=0; a following LW @0x20 still reads 0x11223344.
- Wrap and back-to-back, DEPTH=256: SW 0xCAFEF00D @0x400 aliases word 0; req held high for 3 accesses with WAIT_STATES=0 -> ready every 2 cycles; LW @0x0 = 0xCAFEF00D.
- Reset mid-access: WAIT_STATES=3, SW 0x55AA55AA @0x40, clr pulsed in WAIT -> no ready; after the sweep, LW @0x40 = 0x00000000.
